mem_burst_ctrl: RTL

Burst transaction engine sitting directly upstream of the single-port `memory` block (WIDTH 32, DEPTH 256). It accepts one burst command at a time: start address, length, and direction. For writes it pulls words from a write-data stream; for reads it pushes words onto a read-data stream. Each word is issued to the memory as an individual valid/ready access at consecutive addresses.

---
 rtl/mem_burst_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_ctrl
// Purpose  : Burst transaction engine placed in front of the single-port
//            memory. It accepts one burst command (start address, length,
//            direction) and turns it into one valid/ready memory access per
//            word at consecutive addresses (modulo 2^ADDRE). Write bursts
//            pull words from the wdata stream. Read bursts push words onto
//            the rdata stream.
// Ports    : clk_i, rst_i (async, active-low)
//            cmd_valid_i/cmd_ready_o, cmd_wr_i, cmd_addr_i, cmd_len_i
//            wdata_valid_i/wdata_ready_o, wdata_i
//            rdata_valid_o/rdata_ready_i, rdata_o
//            mem_valid_o, mem_wrdata_o, mem_addre_o, mem_write_o,
//            mem_read_i, mem_ready_i
//            done_o (one-cycle burst-end pulse), err_o (timeout abort)
// Options  : MEM_BURST_TIMEOUT_EN - abort a memory access that has waited
//            255 cycles for mem_ready_i. When this macro is undefined,
//            err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int ADDRE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_wr_i,
    input  logic [ADDRE-1:0] cmd_addr_i,
    input  logic [ADDRE:0]   cmd_len_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             mem_valid_o,
    output logic             mem_wrdata_o,
    output logic [ADDRE-1:0] mem_addre_o,
    output logic [WIDTH-1:0] mem_write_o,
    input  logic [WIDTH-1:0] mem_read_i,
    input  logic             mem_ready_i,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [ADDRE:0] c_max_len = (ADDRE+1)'(DEPTH);
    localparam logic [ADDRE:0] c_one_len = (ADDRE+1)'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_FETCH = 3'd1,
        WR_ISSUE = 3'd2,
        RD_ISSUE = 3'd3,
        RD_OUT   = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDRE-1:0]   r_addr, w_addr_nxt;
    logic [ADDRE:0]     r_rem, w_rem_nxt;
    logic [WIDTH-1:0]   r_rdata, w_rdata_nxt;
    logic [WIDTH-1:0]   r_mem_write, w_mem_write_nxt;
    logic [ADDRE-1:0]   r_mem_addre, w_mem_addre_nxt;
    logic               r_cmd_ready, w_cmd_ready_nxt;
    logic               r_wdata_ready, w_wdata_ready_nxt;
    logic               r_rdata_valid, w_rdata_valid_nxt;
    logic               r_mem_valid, w_mem_valid_nxt;
    logic               r_mem_wrdata, w_mem_wrdata_nxt;
    logic               r_done, w_done_nxt;
    logic [ADDRE:0]     w_len_sat;
    logic               w_last;
    logic               w_timeout;

    // Lengths beyond the memory depth saturate. A full-depth burst is legal
    // because the remaining counter is one bit wider than the address.
    assign w_len_sat = (cmd_len_i > c_max_len) ? c_max_len : cmd_len_i;
    assign w_last    = (r_rem == c_one_len);

`ifdef MEM_BURST_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_err;

    // Fires on the edge where the wait counter would reach 255.
    assign w_timeout = r_mem_valid && !mem_ready_i && (r_to_cnt == 8'd254);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_to_cnt <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_mem_valid && !mem_ready_i && !w_timeout) ? r_to_cnt + 8'd1 : 8'd0;
            r_err    <= w_timeout;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State and all outputs are registered together. An asynchronous reset
    // drops mem_valid_o immediately and abandons any burst in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            r_rdata       <= '0;
            r_mem_write   <= '0;
            r_mem_addre   <= '0;
            r_cmd_ready   <= 1'b0;
            r_wdata_ready <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_wrdata  <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_rem         <= w_rem_nxt;
            r_rdata       <= w_rdata_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_mem_addre   <= w_mem_addre_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_wdata_ready <= w_wdata_ready_nxt;
            r_rdata_valid <= w_rdata_valid_nxt;
            r_mem_valid   <= w_mem_valid_nxt;
            r_mem_wrdata  <= w_mem_wrdata_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // The next-state logic also computes the next value of each registered
    // output. As a result, every output matches the state it is entering.
    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_rem_nxt         = r_rem;
        w_rdata_nxt       = r_rdata;
        w_mem_write_nxt   = r_mem_write;
        w_mem_addre_nxt   = '0;
        w_cmd_ready_nxt   = 1'b0;
        w_wdata_ready_nxt = 1'b0;
        w_rdata_valid_nxt = 1'b0;
        w_mem_valid_nxt   = 1'b0;
        w_mem_wrdata_nxt  = 1'b0;
        w_done_nxt        = 1'b0;

        case (r_state)
            IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid_i && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_addr_nxt      = cmd_addr_i;
                    w_rem_nxt       = w_len_sat;
                    if (w_len_sat == '0) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else if (cmd_wr_i) begin
                        w_state_nxt       = WR_FETCH;
                        w_wdata_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = RD_ISSUE;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addre_nxt = cmd_addr_i;
                    end
                end
            end

            WR_FETCH: begin
                w_wdata_ready_nxt = 1'b1;
                if (wdata_valid_i && r_wdata_ready) begin
                    w_wdata_ready_nxt = 1'b0;
                    w_mem_write_nxt   = wdata_i;
                    w_mem_valid_nxt   = 1'b1;
                    w_mem_wrdata_nxt  = 1'b1;
                    w_mem_addre_nxt   = r_addr;
                    w_state_nxt       = WR_ISSUE;
                end
            end

            WR_ISSUE: begin
                if (mem_ready_i) begin
                    w_addr_nxt = r_addr + 1'b1;
                    w_rem_nxt  = r_rem - 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt       = WR_FETCH;
                        w_wdata_ready_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_mem_valid_nxt  = 1'b1;
                    w_mem_wrdata_nxt = 1'b1;
                    w_mem_addre_nxt  = r_mem_addre;
                end
            end

            RD_ISSUE: begin
                if (mem_ready_i) begin
                    w_rdata_nxt       = mem_read_i;
                    w_rdata_valid_nxt = 1'b1;
                    w_state_nxt       = RD_OUT;
                end else if (w_timeout) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_addre_nxt = r_mem_addre;
                end
            end

            RD_OUT: begin
                if (rdata_ready_i) begin
                    w_addr_nxt = r_addr + 1'b1;
                    w_rem_nxt  = r_rem - 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt     = RD_ISSUE;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addre_nxt = r_addr + 1'b1;
                    end
                end else begin
                    w_rdata_valid_nxt = 1'b1;
                end
            end

            DONE: begin
                w_state_nxt     = IDLE;
                w_cmd_ready_nxt = 1'b1;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign wdata_ready_o = r_wdata_ready;
    assign rdata_valid_o = r_rdata_valid;
    assign rdata_o       = r_rdata;
    assign mem_valid_o   = r_mem_valid;
    assign mem_wrdata_o  = r_mem_wrdata;
    assign mem_addre_o   = r_mem_addre;
    assign mem_write_o   = r_mem_write;
    assign done_o        = r_done;

endmodule
`default_nettype wire
